// File: rtl/fp_normalize_pack.sv
// FP32 adder back end: iterative left-normalise, round-to-nearest-even, IEEE-754 pack.
// Build option FP_FLUSH_SUBNORM_EN flushes subnormal results to signed zero.
module fp_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_sign_i,
    input  logic [EXP_W-1:0]      in_exp_i,
    input  logic [FRAC_W+3:0]     in_mant_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [EXP_W+FRAC_W:0] out_result_o,
    output logic                  out_overflow_o,
    output logic                  out_inexact_o,
    output logic                  out_underflow_o
);

    localparam int MANT_W = FRAC_W + 4;
    localparam int RES_W  = 1 + EXP_W + FRAC_W;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_TWO = {{(EXP_W-1){1'b0}}, 2'b10};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

    typedef struct packed {
        logic             overflow;
        logic             inexact;
        logic             underflow;
        logic [RES_W-1:0] result;
    } pack_t;

    // mant holds {hidden, frac, guard, sticky}; the carry bit is already resolved.
    function automatic pack_t round_pack(input logic sign, input logic [EXP_W:0] exp,
                                         input logic [MANT_W-2:0] mant);
        logic              round_up;
        logic [FRAC_W+1:0] sum;
        logic [FRAC_W:0]   sig;
        logic [EXP_W:0]    exp_r;
        logic [EXP_W-1:0]  exp_field;
        pack_t             r;
        r        = '0;
        round_up = mant[1] & (mant[0] | mant[2]);
        r.inexact = mant[1] | mant[0];
        sum = {1'b0, mant[MANT_W-2:2]} + {{(FRAC_W+1){1'b0}}, round_up};
        if (sum[FRAC_W+1]) begin
            sig   = sum[FRAC_W+1:1];
            exp_r = exp + EXP_ONE;
        end else begin
            sig   = sum[FRAC_W:0];
            exp_r = exp;
        end
        if (exp_r >= EXP_MAX) begin
            r.result   = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            r.overflow = 1'b1;
            r.inexact  = 1'b1;
        end else begin
            exp_field = sig[FRAC_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}};
`ifdef FP_FLUSH_SUBNORM_EN
            if (exp_field == '0 && sig[FRAC_W-1:0] != '0) begin
                r.result    = {sign, {(RES_W-1){1'b0}}};
                r.underflow = 1'b1;
                r.inexact   = 1'b1;
            end else begin
                r.result    = {sign, exp_field, sig[FRAC_W-1:0]};
                r.underflow = (exp_field == '0) & r.inexact;
            end
`else
            r.result    = {sign, exp_field, sig[FRAC_W-1:0]};
            r.underflow = (exp_field == '0) & r.inexact;
`endif
        end
        return r;
    endfunction

    state_t              state_q;
    logic                sign_q;
    logic [EXP_W:0]      exp_q;
    logic [MANT_W-1:0]   mant_q;
    logic [RES_W-1:0]    result_q;
    logic                overflow_q;
    logic                inexact_q;
    logic                underflow_q;
    pack_t               rnd;

    always_comb begin
        rnd = round_pack(sign_q, exp_q, mant_q[MANT_W-2:0]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        sign_q  <= in_sign_i;
                        exp_q   <= {1'b0, in_exp_i};
                        mant_q  <= in_mant_i;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (mant_q == '0) begin
                        result_q <= {sign_q, {(RES_W-1){1'b0}}};
                        state_q  <= DONE;
                    end else if (mant_q[MANT_W-1]) begin
                        // Carry out of the add: shift right once, folding the lost bit into sticky.
                        mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                        exp_q  <= exp_q + EXP_ONE;
                        if (exp_q == EXP_MAX - EXP_ONE) begin
                            result_q   <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                            overflow_q <= 1'b1;
                            inexact_q  <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= ROUND;
                        end
                    end else if (!mant_q[MANT_W-2] && exp_q > EXP_ONE) begin
                        state_q <= NORM;
                    end else begin
                        state_q <= ROUND;
                    end
                end
                NORM: begin
                    // Guard shifts into frac[0]; sticky stays in place.
                    mant_q <= {1'b0, mant_q[MANT_W-3:1], 1'b0, mant_q[0]};
                    exp_q  <= exp_q - EXP_ONE;
                    if (mant_q[MANT_W-3] || exp_q == EXP_TWO) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= rnd.result;
                    overflow_q  <= rnd.overflow;
                    inexact_q   <= rnd.inexact;
                    underflow_q <= rnd.underflow;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        result_q    <= '0;
                        overflow_q  <= 1'b0;
                        inexact_q   <= 1'b0;
                        underflow_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o      = (state_q == IDLE);
    assign out_valid_o     = (state_q == DONE);
    assign out_result_o    = result_q;
    assign out_overflow_o  = overflow_q;
    assign out_inexact_o   = inexact_q;
    assign out_underflow_o = underflow_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack: hand-computed FP32 results, flags and latencies.
module tb_fp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_inexact;
    logic        out_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_normalize_pack #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_sign_i      (in_sign),
        .in_exp_i       (in_exp),
        .in_mant_i      (in_mant),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_result_o   (out_result),
        .out_overflow_o (out_overflow),
        .out_inexact_o  (out_inexact),
        .out_underflow_o(out_underflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'b0, out_overflow, out_inexact, out_underflow};
    endfunction

    // Sends one operand, waits (bounded) for out_valid and checks latency/result/flags.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [26:0] m, input int lat, input logic [31:0] res,
                          input logic [2:0] flg, input logic [2:0] fmask);
        int cyc;
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, out_result, res);
        check({tag, "_flags"}, flags() & {29'b0, fmask}, {29'b0, flg & fmask});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_hs"}, {30'b0, in_ready, out_valid}, 32'd2);
        check({tag, "_idle_flags"}, flags(), 32'd0);
    endtask

    initial begin
        logic [31:0] sub_res;
        logic [31:0] floor_res;
        logic [2:0]  floor_flg;
`ifdef FP_FLUSH_SUBNORM_EN
        sub_res   = 32'h0000_0000;
        floor_res = 32'h0000_0000;
        floor_flg = 3'b011;
`else
        sub_res   = 32'h0040_0000;
        floor_res = 32'h0040_0000;
        floor_flg = 3'b000;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 27'd0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_hs", {30'b0, in_ready, out_valid}, 32'd2);
        check("reset_result", out_result, 32'd0);
        check("reset_flags", flags(), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("one_plus_one", 1'b0, 8'd127, 27'h400_0000, 3, 32'h4000_0000, 3'b000, 3'b111);
        release_out("one_plus_one");
        run_op("cancel", 1'b0, 8'd130, 27'h040_0000, 6, 32'h3F80_0000, 3'b000, 3'b111);
        release_out("cancel");
        run_op("zero_neg", 1'b1, 8'd100, 27'h000_0000, 2, 32'h8000_0000, 3'b000, 3'b111);
        release_out("zero_neg");
        run_op("zero_pos", 1'b0, 8'd100, 27'h000_0000, 2, 32'h0000_0000, 3'b000, 3'b111);
        release_out("zero_pos");
        run_op("rne_carry", 1'b0, 8'd127, 27'h3FF_FFFE, 3, 32'h4000_0000, 3'b010, 3'b111);
        release_out("rne_carry");
        run_op("rne_tie_even", 1'b0, 8'd127, 27'h200_000A, 3, 32'h3F80_0002, 3'b010, 3'b111);
        release_out("rne_tie_even");
        run_op("rne_tie_odd", 1'b0, 8'd127, 27'h200_0006, 3, 32'h3F80_0002, 3'b010, 3'b111);
        release_out("rne_tie_odd");
        run_op("overflow", 1'b0, 8'd254, 27'h400_0000, 2, 32'h7F80_0000, 3'b100, 3'b101);
        release_out("overflow");
        run_op("max_shift", 1'b0, 8'd30, 27'h000_0002, 27, 32'h0300_0000, 3'b000, 3'b111);
        release_out("max_shift");
        run_op("norm_floor", 1'b0, 8'd3, 27'h040_0000, 5, floor_res, floor_flg, 3'b111);
        release_out("norm_floor");

        run_op("subnormal", 1'b0, 8'd1, 27'h100_0002, 3, sub_res, 3'b011, 3'b111);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", out_result, sub_res);
            check("hold_flags", flags(), 32'd3);
        end
        release_out("subnormal");

        // Abort an operand while it is still normalising.
        in_sign  = 1'b0;
        in_exp   = 8'd30;
        in_mant  = 27'h000_0002;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("norm_reset_hs", {30'b0, in_ready, out_valid}, 32'd2);
        check("norm_reset_result", out_result, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("after_reset_hs", {30'b0, in_ready, out_valid}, 32'd2);

        run_op("post_reset", 1'b1, 8'd127, 27'h400_0000, 3, 32'hC000_0000, 3'b000, 3'b111);
        release_out("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
